// File: rtl/online_test_sequencer_r4.sv
// Stimulus sequencer for digit-serial radix-4 signed-digit online adders.
// Walks a bank of ROM vectors. Each vector is streamed MSD-first into the adder,
// and the delayed output digits are captured and compared bit-exactly against
// the expected word. Pass/fail tallies accumulate across the run.
//
// Handshake: dut_en qualifies dut_x_digit/dut_y_digit. One digit pair is sent
// per cycle while dut_en=1, and there is no backpressure. The adder must present
// dut_z_digit in the same cycle as the matching enabled input cycle.
// dut_clr is a one-cycle pulse that is never coincident with dut_en.
module online_test_sequencer_r4 #(
  parameter int N         = 6,
  parameter int C         = 3,
  parameter int DELTA     = 2,
  parameter int NUM_TESTS = 8,
  localparam int W        = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [W-1:0]       test_sel,
  input  logic [N*C-1:0]     vec_x,
  input  logic [N*C-1:0]     vec_y,
  input  logic [(N+1)*C-1:0] vec_z,
  output logic               dut_clr,
  output logic               dut_en,
  output logic [C-1:0]       dut_x_digit,
  output logic [C-1:0]       dut_y_digit,
  input  logic [C-1:0]       dut_z_digit,
  output logic               busy,
  output logic               done,
  output logic [W:0]         pass_count,
  output logic [W:0]         fail_count,
  output logic [W-1:0]       first_fail_idx,
  output logic               first_fail_valid,
  output logic [(N+1)*C-1:0] cap_z
);

  localparam int XW = N * C;
  localparam int ZW = (N + 1) * C;
  localparam int KW = $clog2(N + DELTA + 1);
  localparam int LW = (DELTA > 0) ? $clog2(DELTA + 1) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Current state; kept as a named signal so checkers can bind to it.
  state_t        state;
  logic [XW-1:0] x_sh;
  logic [XW-1:0] y_sh;
  logic [ZW-1:0] z_ref;
  logic [ZW-1:0] cap;
  logic [KW-1:0] k;
  // Counts down the online delay; capture starts when it reaches zero.
  logic [LW-1:0] lead;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      test_sel         <= '0;
      dut_clr          <= 1'b0;
      dut_en           <= 1'b0;
      dut_x_digit      <= '0;
      dut_y_digit      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
      cap_z            <= '0;
      x_sh             <= '0;
      y_sh             <= '0;
      z_ref            <= '0;
      cap              <= '0;
      k                <= '0;
      lead             <= '0;
    end else begin
      dut_clr <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            cap_z            <= '0;
            test_sel         <= '0;
            dut_clr          <= 1'b1;
            busy             <= 1'b1;
            done             <= 1'b0;
            state            <= CLEAR;
          end
        end
        CLEAR: begin
          // The ROM settles on test_sel during this cycle.
          state <= LOAD;
        end
        LOAD: begin
          // The MSD goes out immediately. The shifters hold the remaining digits
          // and fill with zeros, which provides the flush digits for free.
          x_sh        <= vec_x << C;
          y_sh        <= vec_y << C;
          z_ref       <= vec_z;
          cap         <= '0;
          k           <= '0;
          lead        <= LW'(DELTA);
          dut_en      <= 1'b1;
          dut_x_digit <= vec_x[XW-1 -: C];
          dut_y_digit <= vec_y[XW-1 -: C];
          state       <= RUN;
        end
        RUN: begin
          if (lead == '0) begin
            cap <= {cap[ZW-C-1:0], dut_z_digit};
          end else begin
            lead <= lead - LW'(1);
          end
          if (k == KW'(N + DELTA)) begin
            dut_en      <= 1'b0;
            dut_x_digit <= '0;
            dut_y_digit <= '0;
            state       <= CHECK;
          end else begin
            k           <= k + KW'(1);
            dut_x_digit <= x_sh[XW-1 -: C];
            dut_y_digit <= y_sh[XW-1 -: C];
            x_sh        <= x_sh << C;
            y_sh        <= y_sh << C;
          end
        end
        CHECK: begin
          // Exact encoding compare: redundant but equal-valued results fail.
          if (cap == z_ref) begin
            if (pass_count != (W+1)'(NUM_TESTS)) pass_count <= pass_count + (W+1)'(1);
          end else begin
            if (fail_count != (W+1)'(NUM_TESTS)) fail_count <= fail_count + (W+1)'(1);
            if (!first_fail_valid) begin
              first_fail_idx   <= test_sel;
              first_fail_valid <= 1'b1;
            end
          end
          cap_z <= cap;
          if (test_sel == W'(NUM_TESTS - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            test_sel <= test_sel + W'(1);
            dut_clr  <= 1'b1;
            state    <= CLEAR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_online_test_sequencer_r4.sv
// Bench for online_test_sequencer_r4: a default instance plus a small
// N=4/DELTA=0/NUM_TESTS=2 instance, each driven by a vector ROM and a
// table-driven online adder model with optional fault injection.
module tb_online_test_sequencer_r4;

  localparam int N = 6, C = 3, DELTA = 2, NT = 8, W = 3;
  localparam int XW = N * C, ZW = (N + 1) * C;
  localparam int N2 = 4, D2 = 0, NT2 = 2, W2 = 1;
  localparam int XW2 = N2 * C, ZW2 = (N2 + 1) * C;

  typedef struct packed {
    logic [7:0]    pass;
    logic [7:0]    fail;
    logic          ffv;
    logic [7:0]    ffi;
    logic [ZW-1:0] capz;
    logic [15:0]   cyc;
  } res_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   edge_cnt = 0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- vector tables (MSD first) ----------------
  int tx[NT][N] = '{'{0,0,0,0,0,0}, '{0,0,0,0,0,1}, '{3,3,3,3,3,3}, '{-3,-3,-3,-3,-3,-3},
                    '{1,0,0,0,0,0}, '{2,2,2,2,2,2}, '{0,1,-1,2,-2,3}, '{1,2,-3,3,0,-1}};
  int ty[NT][N] = '{'{0,0,0,0,0,0}, '{0,0,0,0,0,1}, '{0,0,0,0,0,1}, '{-3,-3,-3,-3,-3,-3},
                    '{-1,0,0,0,0,0}, '{1,1,1,1,1,1}, '{3,-2,2,-1,1,0}, '{2,-1,-3,3,2,2}};
  int tz[NT][N+1] = '{'{0,0,0,0,0,0,0}, '{0,0,0,0,0,0,2}, '{1,0,0,0,0,0,0}, '{-2,0,0,0,0,0,2},
                      '{0,0,0,0,0,0,0}, '{0,3,3,3,3,3,3}, '{0,3,-1,1,1,-1,3}, '{1,-1,0,-1,2,2,1}};
  int bx[NT2][N2]   = '{'{1,2,3,-1}, '{3,3,3,3}};
  int by[NT2][N2]   = '{'{0,1,-3,2}, '{0,0,0,1}};
  int bz[NT2][N2+1] = '{'{0,1,3,0,1}, '{1,0,0,0,0}};

  logic [XW-1:0]  rom_x[NT];
  logic [XW-1:0]  rom_y[NT];
  logic [ZW-1:0]  rom_z[NT];
  logic [XW2-1:0] romb_x[NT2];
  logic [XW2-1:0] romb_y[NT2];
  logic [ZW2-1:0] romb_z[NT2];

  initial begin
    for (int t = 0; t < NT; t++) begin
      for (int i = 0; i < N; i++) begin
        rom_x[t][(N-1-i)*C +: C] = C'(tx[t][i]);
        rom_y[t][(N-1-i)*C +: C] = C'(ty[t][i]);
      end
      for (int i = 0; i <= N; i++) rom_z[t][(N-i)*C +: C] = C'(tz[t][i]);
    end
    for (int t = 0; t < NT2; t++) begin
      for (int i = 0; i < N2; i++) begin
        romb_x[t][(N2-1-i)*C +: C] = C'(bx[t][i]);
        romb_y[t][(N2-1-i)*C +: C] = C'(by[t][i]);
      end
      for (int i = 0; i <= N2; i++) romb_z[t][(N2-i)*C +: C] = C'(bz[t][i]);
    end
  end

  // ---------------- instance A (defaults) ----------------
  logic a_start = 1'b0;
  logic [W-1:0] a_sel, a_ffi;
  logic [XW-1:0] a_vx, a_vy;
  logic [ZW-1:0] a_vz, a_capz;
  logic a_clr, a_en, a_busy, a_done, a_ffv;
  logic [C-1:0] a_xd, a_yd, a_zd;
  logic [W:0] a_pass, a_fail;

  assign a_vx = rom_x[a_sel];
  assign a_vy = rom_y[a_sel];
  assign a_vz = rom_z[a_sel];

  online_test_sequencer_r4 #(.N(N), .C(C), .DELTA(DELTA), .NUM_TESTS(NT)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .test_sel(a_sel),
    .vec_x(a_vx), .vec_y(a_vy), .vec_z(a_vz),
    .dut_clr(a_clr), .dut_en(a_en), .dut_x_digit(a_xd), .dut_y_digit(a_yd),
    .dut_z_digit(a_zd), .busy(a_busy), .done(a_done),
    .pass_count(a_pass), .fail_count(a_fail),
    .first_fail_idx(a_ffi), .first_fail_valid(a_ffv), .cap_z(a_capz)
  );

  // Adder model A: output digit j appears on enabled cycle DELTA+j.
  int   ma_m = 0;
  int   pa;
  logic fault_en = 1'b0;
  always @(posedge clk) begin
    if (a_clr) ma_m <= 0;
    else if (a_en) ma_m <= ma_m + 1;
  end
  always_comb begin
    a_zd = '0;
    pa = N - (ma_m - DELTA);
    if (a_en && ma_m >= DELTA && pa >= 0) begin
      a_zd = rom_z[a_sel][pa*C +: C];
      if (fault_en && (a_sel == 3'd3 || a_sel == 3'd5) && pa == 2) a_zd = ~rom_z[a_sel][pa*C +: C];
    end
  end

  // ---------------- instance B (N=4, DELTA=0, NUM_TESTS=2) ----------------
  logic b_start = 1'b0;
  logic [W2-1:0] b_sel, b_ffi;
  logic [XW2-1:0] b_vx, b_vy;
  logic [ZW2-1:0] b_vz, b_capz;
  logic b_clr, b_en, b_busy, b_done, b_ffv;
  logic [C-1:0] b_xd, b_yd, b_zd;
  logic [W2:0] b_pass, b_fail;

  assign b_vx = romb_x[b_sel];
  assign b_vy = romb_y[b_sel];
  assign b_vz = romb_z[b_sel];

  online_test_sequencer_r4 #(.N(N2), .C(C), .DELTA(D2), .NUM_TESTS(NT2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .test_sel(b_sel),
    .vec_x(b_vx), .vec_y(b_vy), .vec_z(b_vz),
    .dut_clr(b_clr), .dut_en(b_en), .dut_x_digit(b_xd), .dut_y_digit(b_yd),
    .dut_z_digit(b_zd), .busy(b_busy), .done(b_done),
    .pass_count(b_pass), .fail_count(b_fail),
    .first_fail_idx(b_ffi), .first_fail_valid(b_ffv), .cap_z(b_capz)
  );

  int mb_m = 0;
  int pb;
  always @(posedge clk) begin
    if (b_clr) mb_m <= 0;
    else if (b_en) mb_m <= mb_m + 1;
  end
  always_comb begin
    b_zd = '0;
    pb = N2 - (mb_m - D2);
    if (b_en && mb_m >= D2 && pb >= 0) b_zd = romb_z[b_sel][pb*C +: C];
  end

  // ---------------- scoreboard queues ----------------
  logic [2*C-1:0] exp_q[$];
  logic [2*C-1:0] exp_q2[$];
  res_t res_q[$];
  res_t res_q2[$];
  int a_start_edge = 0;
  int b_start_edge = 0;

  task automatic push_digits_a();
    for (int t = 0; t < NT; t++)
      for (int k = 0; k <= N + DELTA; k++)
        exp_q.push_back((k < N) ? {C'(tx[t][k]), C'(ty[t][k])} : '0);
  endtask

  task automatic push_digits_b();
    for (int t = 0; t < NT2; t++)
      for (int k = 0; k <= N2 + D2; k++)
        exp_q2.push_back((k < N2) ? {C'(bx[t][k]), C'(by[t][k])} : '0);
  endtask

  task automatic push_res(input bit to_b, input int p, input int f, input int v,
                          input int i, input logic [ZW-1:0] z, input int cyc);
    res_t r;
    r.pass = 8'(p); r.fail = 8'(f); r.ffv = v[0]; r.ffi = 8'(i); r.capz = z; r.cyc = 16'(cyc);
    if (to_b) res_q2.push_back(r);
    else res_q.push_back(r);
  endtask

  // ---------------- monitor A ----------------
  logic a_done_q = 1'b0;
  always @(negedge clk) begin
    res_t r;
    if (rst_n) begin
      chk("a_clr_en_excl", 64'(a_clr & a_en), 64'd0);
      if (a_en) begin
        if (exp_q.size() == 0) chk("a_digit_unexpected", 64'd1, 64'd0);
        else chk("a_digits", 64'({a_xd, a_yd}), 64'(exp_q.pop_front()));
      end else begin
        chk("a_idle_digits", 64'({a_xd, a_yd}), 64'd0);
      end
      if (a_done && !a_done_q) begin
        if (res_q.size() == 0) chk("a_done_unexpected", 64'd1, 64'd0);
        else begin
          r = res_q.pop_front();
          chk("a_pass_count", 64'(a_pass), 64'(r.pass));
          chk("a_fail_count", 64'(a_fail), 64'(r.fail));
          chk("a_ff_valid", 64'(a_ffv), 64'(r.ffv));
          chk("a_ff_idx", 64'(a_ffi), 64'(r.ffi));
          chk("a_cap_z", 64'(a_capz), 64'(r.capz));
          chk("a_done_cycle", 64'(edge_cnt - a_start_edge + 1), 64'(r.cyc));
          chk("a_busy_at_done", 64'(a_busy), 64'd0);
        end
      end
    end
    a_done_q <= a_done;
  end

  // ---------------- monitor B ----------------
  logic b_done_q = 1'b0;
  always @(negedge clk) begin
    res_t r;
    if (rst_n) begin
      chk("b_clr_en_excl", 64'(b_clr & b_en), 64'd0);
      if (b_en) begin
        if (exp_q2.size() == 0) chk("b_digit_unexpected", 64'd1, 64'd0);
        else chk("b_digits", 64'({b_xd, b_yd}), 64'(exp_q2.pop_front()));
      end else begin
        chk("b_idle_digits", 64'({b_xd, b_yd}), 64'd0);
      end
      if (b_done && !b_done_q) begin
        if (res_q2.size() == 0) chk("b_done_unexpected", 64'd1, 64'd0);
        else begin
          r = res_q2.pop_front();
          chk("b_pass_count", 64'(b_pass), 64'(r.pass));
          chk("b_fail_count", 64'(b_fail), 64'(r.fail));
          chk("b_ff_valid", 64'(b_ffv), 64'(r.ffv));
          chk("b_cap_z", 64'(b_capz), 64'(r.capz));
          chk("b_done_cycle", 64'(edge_cnt - b_start_edge + 1), 64'(r.cyc));
        end
      end
    end
    b_done_q <= b_done;
  end

  // ---------------- driver tasks ----------------
  task automatic start_a();
    @(negedge clk);
    a_start = 1'b1;
    a_start_edge = edge_cnt + 1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic start_b();
    @(negedge clk);
    b_start = 1'b1;
    b_start_edge = edge_cnt + 1;
    @(negedge clk);
    b_start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int i = 0;
    while (!a_done && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (!a_done) chk("a_done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_done_b(input int budget);
    int i = 0;
    while (!b_done && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (!b_done) chk("b_done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_a_sel"}, 64'(a_sel), 64'd0);
    chk({tag, "_a_ctl"}, 64'({a_clr, a_en, a_busy, a_done}), 64'd0);
    chk({tag, "_a_digits"}, 64'({a_xd, a_yd}), 64'd0);
    chk({tag, "_a_counts"}, 64'({a_pass, a_fail}), 64'd0);
    chk({tag, "_a_ff"}, 64'({a_ffv, a_ffi}), 64'd0);
    chk({tag, "_a_cap_z"}, 64'(a_capz), 64'd0);
    chk({tag, "_a_state"}, 64'(dut_a.state), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk_zero_a("reset");
    chk("reset_b_ctl", 64'({b_clr, b_en, b_busy, b_done, b_pass, b_fail}), 64'd0);
    rst_n = 1'b1;

    // Run 1: clean run with a start pulse in RUN of test 2 (cycle 30).
    push_digits_a();
    push_res(1'b0, 8, 0, 0, 0, rom_z[7], 97);
    start_a();
    repeat (28) @(negedge clk);
    chk("a_state_run_t2", 64'(dut_a.state), 64'd3);
    chk("a_sel_t2", 64'(a_sel), 64'd2);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_done_a(300);

    // Run 2: restart from DONE, counters cleared in the first cycle.
    repeat (3) @(negedge clk);
    chk("a_done_held", 64'(a_done), 64'd1);
    chk("a_pass_held", 64'(a_pass), 64'd8);
    push_digits_a();
    push_res(1'b0, 8, 0, 0, 0, rom_z[7], 97);
    start_a();
    chk("a_restart_counts", 64'({a_pass, a_fail, a_ffv}), 64'd0);
    chk("a_restart_cap_z", 64'(a_capz), 64'd0);
    chk("a_restart_ctl", 64'({a_clr, a_en, a_busy, a_done}), 64'b1010);
    wait_done_a(300);

    // Run 3: model corrupts one output digit on tests 3 and 5.
    fault_en = 1'b1;
    push_digits_a();
    push_res(1'b0, 6, 2, 1, 3, rom_z[7], 97);
    start_a();
    wait_done_a(300);
    fault_en = 1'b0;

    // Run 4: reset for one cycle during RUN of test 4 (cycle 54).
    push_digits_a();
    start_a();
    repeat (53) @(negedge clk);
    chk("a_state_run_t4", 64'(dut_a.state), 64'd3);
    chk("a_sel_t4", 64'(a_sel), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_a("midrun_reset");
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Run 5: clean run after the abort.
    push_digits_a();
    push_res(1'b0, 8, 0, 0, 0, rom_z[7], 97);
    start_a();
    wait_done_a(300);

    // Variant instance: per-test length 8, done at cycle 17.
    push_digits_b();
    push_res(1'b1, 2, 0, 0, 0, ZW'(romb_z[1]), 17);
    start_b();
    wait_done_b(100);

    chk("a_exp_q_empty", 64'(exp_q.size() + res_q.size()), 64'd0);
    chk("b_exp_q_empty", 64'(exp_q2.size() + res_q2.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog: guarantees termination even if the main sequence stalls.
  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
